// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD responder: bus control codes,
// FSM state encoding, DDRAM geometry, instruction bit positions and
// helpers for the HD44780 DDRAM address encoding.
package lcd_pkg;

  // lcd_ctrl = {RS, RW}
  localparam logic [1:0] CTRL_CMD   = 2'b00;
  localparam logic [1:0] CTRL_BF    = 2'b01;
  localparam logic [1:0] CTRL_DATA  = 2'b10;
  localparam logic [1:0] CTRL_RDATA = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  localparam logic [6:0] LINE2_BASE  = 7'h40;
  localparam logic [7:0] CHAR_SPACE  = 8'h20;
  localparam int         DDRAM_DEPTH = 32;

  // Instruction class is selected by the highest set bit.
  localparam int CMD_SETDD_BIT = 7;
  localparam int CMD_CGRAM_BIT = 6;
  localparam int CMD_FUNC_BIT  = 5;
  localparam int CMD_SHIFT_BIT = 4;
  localparam int CMD_DISP_BIT  = 3;
  localparam int CMD_ENTRY_BIT = 2;
  localparam int CMD_HOME_BIT  = 1;
  localparam int CMD_CLEAR_BIT = 0;
  localparam int DISP_D_BIT    = 2;
  localparam int ENTRY_ID_BIT  = 1;

  // DDRAM address -> RAM index {line, column}.
  function automatic logic [4:0] ram_idx(input logic [6:0] addr);
    return {addr[6], addr[3:0]};
  endfunction

  // Cursor step with line wrap: 0x0F<->0x40 and 0x4F<->0x00.
  function automatic logic [6:0] cursor_step(input logic [6:0] addr, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (addr[3:0] == 4'hF) nxt = addr[6] ? 7'h00 : LINE2_BASE;
      else                   nxt = {addr[6], 2'b00, addr[3:0] + 4'd1};
    end else begin
      if (addr[3:0] == 4'h0) nxt = addr[6] ? 7'h0F : (LINE2_BASE | 7'h0F);
      else                   nxt = {addr[6], 2'b00, addr[3:0] - 4'd1};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_responder_if.sv
// Host-to-panel LCD bus: data, {RS,RW} control, enable strobe, read-back
// data and busy. master = host (CPU MMIO side), slave = panel responder.
interface lcd_responder_if;
  logic [7:0] lcd_data;
  logic [1:0] lcd_ctrl;
  logic       lcd_enable;
  logic [7:0] lcd_rdata;
  logic       busy;

  modport master (output lcd_data, lcd_ctrl, lcd_enable, input lcd_rdata, busy);
  modport slave  (input lcd_data, lcd_ctrl, lcd_enable, output lcd_rdata, busy);
endinterface

// File: rtl/lcd_ddram.sv
// 32x8 display RAM: one synchronous write port, two combinational reads
// (cursor read-back and display scan). Contents are not reset.
// Ports: clk, we/waddr/wdata, raddr_a/rdata_a, raddr_b/rdata_b.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [4:0] raddr_b,
  output logic [7:0] rdata_b
);

  logic [7:0] mem [DDRAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/lcd_responder.sv
// HD44780-style character-LCD device model: decodes host transfers on the
// falling edge of lcd_enable, keeps a 2x16 DDRAM, cursor, entry mode,
// display-on flag and busy timer, and drives busy-flag/data read-back.
// Ports: clk, rst_n, bus (lcd_data/ctrl/enable in, lcd_rdata/busy out),
// display_on, cursor_addr, char_valid/char_data, scan_addr->scan_char, violation.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = 4,
  parameter int CLEAR_CYCLES = 40   // must cover the 32 RAM clear writes
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_responder_if.slave     bus,
  output logic               display_on,
  output logic [6:0]         cursor_addr,
  output logic               char_valid,
  output logic [7:0]         char_data,
  input  logic [4:0]         scan_addr,
  output logic [7:0]         scan_char,
  output logic               violation
);

  logic [1:0]  state;
  logic [15:0] cnt;
  logic [5:0]  clr_idx;      // bit 5 set once all 32 entries are cleared
  logic        en_q;
  logic        entry_inc;
  logic        fall;
  logic        is_busy;
  logic        data_wr;
  logic        clr_wr;
  logic        ram_we;
  logic [4:0]  ram_waddr;
  logic [7:0]  ram_wdata;
  logic [7:0]  cursor_char;
  logic [7:0]  d;

  assign d       = bus.lcd_data;
  assign fall    = en_q & ~bus.lcd_enable;
  assign is_busy = (state != ST_IDLE);
  assign bus.busy = is_busy;

  assign data_wr = fall && !is_busy && (bus.lcd_ctrl == CTRL_DATA);
  assign clr_wr  = (state == ST_CLEAR) && !clr_idx[5];

  // Clear writes and host data writes never coincide: the latter need IDLE.
  assign ram_we    = data_wr | clr_wr;
  assign ram_waddr = clr_wr ? clr_idx[4:0] : ram_idx(cursor_addr);
  assign ram_wdata = clr_wr ? CHAR_SPACE : d;

  lcd_ddram u_ddram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (ram_idx(cursor_addr)),
    .rdata_a (cursor_char),
    .raddr_b (scan_addr),
    .rdata_b (scan_char)
  );

  always_comb begin
    bus.lcd_rdata = 8'h00;
    if (bus.lcd_enable && bus.lcd_ctrl[0]) begin
      bus.lcd_rdata = bus.lcd_ctrl[1] ? cursor_char : {is_busy, cursor_addr};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      clr_idx     <= '0;
      en_q        <= 1'b0;
      entry_inc   <= 1'b1;
      display_on  <= 1'b0;
      cursor_addr <= 7'h00;
      char_valid  <= 1'b0;
      char_data   <= 8'h00;
      violation   <= 1'b0;
    end else begin
      en_q       <= bus.lcd_enable;
      char_valid <= 1'b0;

      // Busy timers; a fall seen below while still busy is dropped.
      if (state == ST_BUSY) begin
        if (cnt == '0) state <= ST_IDLE;
        else           cnt   <= cnt - 16'd1;
      end else if (state == ST_CLEAR) begin
        if (!clr_idx[5]) clr_idx <= clr_idx + 6'd1;
        if (cnt == '0) state <= ST_IDLE;
        else           cnt   <= cnt - 16'd1;
      end

      if (fall) begin
        if (!bus.lcd_ctrl[0] && is_busy) begin
          violation <= 1'b1;
        end else if (!is_busy) begin
          case (bus.lcd_ctrl)
            CTRL_DATA: begin
              cursor_addr <= cursor_step(cursor_addr, entry_inc);
              char_valid  <= 1'b1;
              char_data   <= d;
              state       <= ST_BUSY;
              cnt         <= 16'(BUSY_CYCLES - 1);
            end
            CTRL_RDATA: begin
              cursor_addr <= cursor_step(cursor_addr, entry_inc);
              state       <= ST_BUSY;
              cnt         <= 16'(BUSY_CYCLES - 1);
            end
            CTRL_CMD: begin
              state <= ST_BUSY;
              cnt   <= 16'(BUSY_CYCLES - 1);
              if (d[CMD_SETDD_BIT]) begin
                cursor_addr <= {d[6], 2'b00, d[3:0]};
              end else if (d[CMD_CGRAM_BIT] || d[CMD_FUNC_BIT] || d[CMD_SHIFT_BIT]) begin
                // CGRAM address, function set and shift are not modelled.
              end else if (d[CMD_DISP_BIT]) begin
                display_on <= d[DISP_D_BIT];
              end else if (d[CMD_ENTRY_BIT]) begin
                entry_inc <= d[ENTRY_ID_BIT];
              end else if (d[CMD_HOME_BIT]) begin
                cursor_addr <= 7'h00;
              end else if (d[CMD_CLEAR_BIT]) begin
                cursor_addr <= 7'h00;
                entry_inc   <= 1'b1;
                clr_idx     <= '0;
                state       <= ST_CLEAR;
                cnt         <= 16'(CLEAR_CYCLES - 1);
              end
            end
            default: ;  // busy-flag read: no state change
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_responder.sv
module tb_lcd_responder;
  import lcd_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] scan_addr = 5'd0;
  logic       display_on, char_valid, violation;
  logic [6:0] cursor_addr;
  logic [7:0] char_data, scan_char;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  lcd_responder_if bus_if ();

  lcd_responder #(.BUSY_CYCLES(4), .CLEAR_CYCLES(40)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if.slave),
    .display_on  (display_on),
    .cursor_addr (cursor_addr),
    .char_valid  (char_valid),
    .char_data   (char_data),
    .scan_addr   (scan_addr),
    .scan_char   (scan_char),
    .violation   (violation)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted data write must emerge as one char_valid pulse.
  always @(negedge clk) begin
    if (rst_n && char_valid) begin
      if (exp_q.size() == 0) chk("char_valid_unexpected", 1, 0);
      else                   chk("char_data", char_data, exp_q.pop_front());
    end
  end

  // One bus transfer, called at a negedge; rd is lcd_rdata while enable is high.
  task automatic xfer(input logic [1:0] c, input logic [7:0] d, output logic [7:0] rd);
    bus_if.lcd_ctrl   = c;
    bus_if.lcd_data   = d;
    bus_if.lcd_enable = 1'b1;
    @(negedge clk);
    rd = bus_if.lcd_rdata;
    bus_if.lcd_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] c, input logic [7:0] d, input bit expect_char);
    logic [7:0] rd;
    if (expect_char) exp_q.push_back(d);
    xfer(c, d, rd);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus_if.busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    count_busy(n);
    if (n >= 1000) chk("busy_timeout", 1, 0);
  endtask

  task automatic chk_scan(input int idx, input logic [7:0] exp);
    scan_addr = 5'(idx);
    #1;
    chk($sformatf("scan_%0d", idx), scan_char, exp);
  endtask

  initial begin
    int n;
    logic [7:0] rd;
    bus_if.lcd_data   = 8'h00;
    bus_if.lcd_ctrl   = 2'b00;
    bus_if.lcd_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_display_on", display_on, 0);
    chk("rst_cursor", cursor_addr, 7'h00);
    chk("rst_violation", violation, 0);
    chk("rst_char_valid", char_valid, 0);
    chk("rst_rdata", bus_if.lcd_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clear, then "Hi"; a data write holds busy for 4 cycles.
    wr(CTRL_CMD, 8'h01, 0);
    wait_idle();
    wr(CTRL_DATA, 8'h48, 1);
    count_busy(n);
    chk("busy_len_data", n, 4);
    wr(CTRL_DATA, 8'h69, 1);
    wait_idle();
    chk_scan(0, 8'h48);
    chk_scan(1, 8'h69);
    chk("cursor_hi", cursor_addr, 7'h02);
    chk("sb_empty_hi", exp_q.size(), 0);

    // Line wrap 0x0F -> 0x40.
    wr(CTRL_CMD, 8'h8F, 0);
    wait_idle();
    chk("cursor_set", cursor_addr, 7'h0F);
    wr(CTRL_DATA, 8'h41, 1);
    wait_idle();
    wr(CTRL_DATA, 8'h42, 1);
    wait_idle();
    chk_scan(15, 8'h41);
    chk_scan(16, 8'h42);
    chk("cursor_wrap", cursor_addr, 7'h41);

    // Clear busy length and contents.
    chk("pre_clear_idle", bus_if.busy, 0);
    wr(CTRL_CMD, 8'h01, 0);
    count_busy(n);
    chk("busy_len_clear", n, 40);
    for (int i = 0; i < 32; i++) chk_scan(i, CHAR_SPACE);
    chk("cursor_clear", cursor_addr, 7'h00);

    // Write while busy: dropped and flagged.
    wr(CTRL_DATA, 8'h51, 1);
    wr(CTRL_DATA, 8'h5A, 0);
    wait_idle();
    chk("violation_set", violation, 1);
    chk_scan(0, 8'h51);
    chk_scan(1, CHAR_SPACE);
    chk("cursor_after_drop", cursor_addr, 7'h01);

    // Decrement mode with wrap 0x00 -> 0x4F, then data read.
    wr(CTRL_CMD, 8'h04, 0);
    wait_idle();
    wr(CTRL_CMD, 8'h80, 0);
    wait_idle();
    wr(CTRL_DATA, 8'h78, 1);
    wait_idle();
    chk_scan(0, 8'h78);
    chk("cursor_dec_wrap", cursor_addr, 7'h4F);
    xfer(CTRL_RDATA, 8'h00, rd);
    chk("rdata_ram31", rd, CHAR_SPACE);
    wait_idle();
    chk("cursor_after_read", cursor_addr, 7'h4E);
    xfer(CTRL_BF, 8'h00, rd);
    chk("bf_idle", rd, 8'h4E);
    chk("rdata_enable_low", bus_if.lcd_rdata, 0);
    chk("violation_sticky", violation, 1);

    // Display on/off.
    wr(CTRL_CMD, 8'h0C, 0);
    wait_idle();
    chk("display_on", display_on, 1);
    wr(CTRL_CMD, 8'h08, 0);
    wait_idle();
    chk("display_off", display_on, 0);
    chk("sb_empty", exp_q.size(), 0);

    // Reset in the middle of a clear.
    wr(CTRL_CMD, 8'h01, 0);
    repeat (3) @(negedge clk);
    xfer(CTRL_BF, 8'h00, rd);
    chk("bf_during_clear", rd[7], 1);
    chk_scan(0, CHAR_SPACE);
    rst_n = 1'b0;
    #1;
    chk("busy_after_reset", bus_if.busy, 0);
    chk("violation_after_reset", violation, 0);
    chk("cursor_after_reset", cursor_addr, 7'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
